// File: rtl/axis_loopback_monitor.sv
// AXI-stream loopback stage: transforms each word, buffers it in a DEPTH-entry FIFO, counts output transfers and drives active-low status LEDs.
// Optional build macro AXIS_LOOPBACK_STRETCH_EN stretches the two activity LEDs to 2^20 cycles per handshake.
module axis_loopback_monitor #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 4,
    parameter int                    MODE       = 1,
    parameter logic [DATA_WIDTH-1:0] KEY        = '0,
    parameter int                    LED_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  ivalid,
    output logic                  iready,
    input  logic                  overflow,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  ovalid,
    input  logic                  oready,
    output logic [15:0]           count,
    output logic [LED_WIDTH-1:0]  leds
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int LOW_W = LED_WIDTH - 3;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [OCC_W-1:0]      occ_reg, occ_next;
    logic                  iready_reg;
    logic                  ovalid_reg;
    logic [DATA_WIDTH-1:0] odata_reg, odata_next;
    logic [15:0]           count_reg;
    logic                  sticky_reg, sticky_next;
    logic [LED_WIDTH-1:0]  leds_reg;
    logic [LOW_W-1:0]      led_low_next;
    logic [1:0]            lit_next;
    logic [LED_WIDTH-1:0]  led_reset_pattern;
    logic [DATA_WIDTH-1:0] xform_data;
    logic                  push;
    logic                  pop;

    // The transform is applied once on the way in; the FIFO holds finished words.
    generate
        if (MODE == 0) begin : g_pass
            assign xform_data = idata;
        end else if (MODE == 1) begin : g_invert
            assign xform_data = ~idata;
        end else if (MODE == 2) begin : g_xor
            assign xform_data = idata ^ KEY;
        end else begin : g_add
            assign xform_data = idata + KEY;
        end
    endgenerate

    for (genvar gi = 0; gi < LED_WIDTH; gi++) begin : g_led_rst
        assign led_reset_pattern[gi] = (gi % 2 == 1);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= xform_data;
        end
    end

    always_comb begin
        push        = ivalid && iready_reg;
        pop         = ovalid_reg && oready;
        wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

        occ_next = occ_reg;
        if (push && !pop) begin
            occ_next = occ_reg + 1'b1;
        end else if (!push && pop) begin
            occ_next = occ_reg - 1'b1;
        end

        // Next head: the word being written if it lands in the head slot, else the stored entry.
        odata_next = odata_reg;
        if (push && (rd_ptr_next == wr_ptr_reg)) begin
            odata_next = xform_data;
        end else if (occ_next != '0) begin
            odata_next = mem[rd_ptr_next];
        end

        sticky_next  = sticky_reg | overflow;
        led_low_next = pop ? ~odata_reg[LOW_W-1:0] : leds_reg[LOW_W-1:0];
    end

`ifdef AXIS_LOOPBACK_STRETCH_EN
    logic [1:0] hs;
    assign hs = {pop, push};

    // Index 1 follows output handshakes, index 0 input handshakes; each stays lit 2^20 cycles.
    for (genvar gi = 0; gi < 2; gi++) begin : g_stretch
        logic [19:0] cnt_reg;
        logic        active_reg;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                cnt_reg    <= '0;
                active_reg <= 1'b0;
            end else if (hs[gi]) begin
                cnt_reg    <= '1;
                active_reg <= 1'b1;
            end else if (active_reg) begin
                if (cnt_reg == '0) begin
                    active_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end

        assign lit_next[gi] = hs[gi] || (active_reg && (cnt_reg != '0));
    end
`else
    assign lit_next = {occ_next != '0, occ_next != FULL_OCC};
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            iready_reg <= 1'b1;
            ovalid_reg <= 1'b0;
            odata_reg  <= '0;
            count_reg  <= '0;
            sticky_reg <= 1'b0;
            leds_reg   <= led_reset_pattern;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            occ_reg    <= occ_next;
            // iready comes only from occupancy, so a pop while full frees the slot one cycle later.
            iready_reg <= (occ_next != FULL_OCC);
            ovalid_reg <= (occ_next != '0);
            odata_reg  <= odata_next;
            if (pop) begin
                count_reg <= count_reg + 16'd1;
            end
            sticky_reg <= sticky_next;
            leds_reg   <= {~sticky_next, ~lit_next[1], ~lit_next[0], led_low_next};
        end
    end

    assign iready = iready_reg;
    assign ovalid = ovalid_reg;
    assign odata  = odata_reg;
    assign count  = count_reg;
    assign leds   = leds_reg;

endmodule

// File: tb/tb_axis_loopback_monitor.sv
// Randomised and directed bench for axis_loopback_monitor: three transform modes share one stimulus stream and a queue-based reference model.
module tb_axis_loopback_monitor;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 8;
    localparam int NDUT  = 3;
    localparam int MODE_TAB [NDUT] = '{1, 3, 2};
    localparam logic [DW-1:0] KEY_TAB [NDUT] = '{8'h00, 8'h02, 8'hA5};
    localparam logic [LW-1:0] LED_RST = 8'b10101010;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] idata = '0;
    logic          ivalid = 1'b0;
    logic          overflow = 1'b0;
    logic          oready = 1'b0;

    logic          iready [NDUT];
    logic          ovalid [NDUT];
    logic [DW-1:0] odata  [NDUT];
    logic [15:0]   count  [NDUT];
    logic [LW-1:0] leds   [NDUT];

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        axis_loopback_monitor #(
            .DATA_WIDTH (DW),
            .DEPTH      (DEPTH),
            .MODE       (MODE_TAB[gi]),
            .KEY        (KEY_TAB[gi]),
            .LED_WIDTH  (LW)
        ) u_dut (
            .clock    (clock),
            .resetn   (resetn),
            .idata    (idata),
            .ivalid   (ivalid),
            .iready   (iready[gi]),
            .overflow (overflow),
            .odata    (odata[gi]),
            .ovalid   (ovalid[gi]),
            .oready   (oready),
            .count    (count[gi]),
            .leds     (leds[gi])
        );
    end

    // Reference model: queue of raw accepted words, transfer count, sticky flag, last-popped LED bits.
    logic [DW-1:0]   q [$];
    int              exp_count = 0;
    bit              sticky = 1'b0;
    bit              leds_live = 1'b0;
    logic [LW-4:0]   low_leds [NDUT];
    int              checks = 0;
    int              fails = 0;
    int              n_pops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] xform(input int d, input logic [DW-1:0] x);
        int s;
        case (MODE_TAB[d])
            0:       return x;
            1:       return ~x;
            2:       return x ^ KEY_TAB[d];
            default: begin
                s = (int'(x) + int'(KEY_TAB[d])) % 256;
                return s[DW-1:0];
            end
        endcase
    endfunction

    task automatic check_outputs();
        logic          exp_ovalid;
        logic          exp_iready;
        logic [LW-1:0] exp_leds;
        exp_ovalid = (q.size() > 0);
        exp_iready = (q.size() < DEPTH);
        for (int d = 0; d < NDUT; d++) begin
            exp_leds = leds_live ? {~sticky, ~exp_ovalid, ~exp_iready, low_leds[d]} : LED_RST;
            check($sformatf("iready[%0d]", d), 32'(iready[d]), 32'(exp_iready));
            check($sformatf("ovalid[%0d]", d), 32'(ovalid[d]), 32'(exp_ovalid));
            if (exp_ovalid) begin
                check($sformatf("odata[%0d]", d), 32'(odata[d]), 32'(xform(d, q[0])));
            end
            check($sformatf("count[%0d]", d), 32'(count[d]), exp_count);
            check($sformatf("leds[%0d]", d), 32'(leds[d]), 32'(exp_leds));
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_count = 0;
        sticky    = 1'b0;
        leds_live = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            low_leds[d] = LED_RST[LW-4:0];
        end
    endtask

    // Called at posedge+1: asserts reset mid-cycle, checks the immediate effect, releases after an edge.
    task automatic do_reset();
        resetn = 1'b0;
        #2;
        model_reset();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_ovalid[%0d]", d), 32'(ovalid[d]), 32'd0);
            check($sformatf("rst_iready[%0d]", d), 32'(iready[d]), 32'd1);
            check($sformatf("rst_count[%0d]", d), 32'(count[d]), 32'd0);
            check($sformatf("rst_leds[%0d]", d), 32'(leds[d]), 32'(LED_RST));
            check($sformatf("rst_odata[%0d]", d), 32'(odata[d]), 32'd0);
        end
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic step(input logic v, input logic [DW-1:0] data, input logic r,
                        input logic ovf, input bit verbose);
        bit            do_push;
        bit            do_pop;
        logic [DW-1:0] w;
        logic [DW-1:0] raw;
        idata    = data;
        ivalid   = v;
        oready   = r;
        overflow = ovf;
        @(negedge clock);
        check_outputs();
        do_push = v && (q.size() < DEPTH);
        do_pop  = r && (q.size() > 0);
        @(posedge clock);
        if (do_pop) begin
            raw = q.pop_front();
            for (int d = 0; d < NDUT; d++) begin
                w = ~xform(d, raw);
                low_leds[d] = w[LW-4:0];
            end
            exp_count = (exp_count + 1) % 65536;
            n_pops++;
            if (verbose) begin
                $display("pop raw=%02h inv=%02h add=%02h xor=%02h count=%0d",
                         raw, xform(0, raw), xform(1, raw), xform(2, raw), exp_count);
            end
        end
        if (do_push) begin
            q.push_back(data);
        end
        sticky    = sticky | ovf;
        leds_live = 1'b1;
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clock);
        #1;
        do_reset();

        // Single word through each transform, including the 8'hFF + 8'h02 wrap.
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Fill to full with the output stalled, then drain in order.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Half-full steady state across several pointer wraps.
        for (int i = 0; i < 2; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h90 + i), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 2) != 0, 1'b0, 1'b1);
        end

        // Sticky overflow from a one-cycle pulse, then reset with three words buffered.
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b1);
        check("buffered_before_reset", q.size(), 32'd3);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Continuous streaming until the 16-bit transfer count wraps.
        n_pops = 0;
        while (n_pops < 65538) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
        end
        $display("streamed %0d transfers, count now %0d", n_pops, exp_count);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("count_wrapped[%0d]", d), 32'(count[d]), 32'd2);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
